tag_issuer: RTL and testbench



---
 rtl/tag_issuer_if.sv | 27 ++
 rtl/tag_issuer.sv | 125 ++++++++++++
 tb/tb_tag_issuer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tag_issuer_if.sv
// Tag/flush/lock handshake bundle between the controller and the column tag issuer.
// master drives job requests and column locks; slave is the issuer itself.
interface tag_issuer_if #(
    parameter int unsigned NUM_COL = 4,
    parameter int unsigned TW      = $clog2(NUM_COL) + 1
);
    logic               start;
    logic [TW-1:0]      num_active;
    logic               stall;
    logic [NUM_COL-1:0] lock_in;
    logic               buf_rstn;
    logic [TW-1:0]      tag_out;
    logic [NUM_COL-1:0] flush_out;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, num_active, stall, lock_in,
        input  buf_rstn, tag_out, flush_out, busy, done, err
    );

    modport slave (
        input  start, num_active, stall, lock_in,
        output buf_rstn, tag_out, flush_out, busy, done, err
    );
endinterface

// File: rtl/tag_issuer.sv
// Column tag issuer: clears the tag buffers, issues tags 1..n with one-hot flushes, waits for locks.
// Define TAG_TIMEOUT_EN to add a watchdog on the lock wait that aborts with an err pulse.
module tag_issuer #(
    parameter int unsigned NUM_COL     = 4,
    parameter int unsigned TW          = $clog2(NUM_COL) + 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic         clk,
    input logic         rst,
    tag_issuer_if.slave bus
);
    localparam int unsigned MW = NUM_COL + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT_LOCK,
        S_FINISH
    } state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      cnt, cnt_nxt;
    logic [TW-1:0]      n_q, n_nxt;
    logic [TW-1:0]      tag_nxt;
    logic [NUM_COL-1:0] flush_nxt;
    logic [NUM_COL-1:0] mask_c;
    logic               buf_rstn_nxt, done_nxt, err_nxt;
    logic               start_ok_c, locked_c, to_hit_c;

    assign start_ok_c = (bus.num_active != '0) && (bus.num_active <= TW'(NUM_COL));
    // MW-bit shift so that n == NUM_COL still yields an all-ones mask
    assign mask_c     = NUM_COL'((MW'(1) << n_q) - MW'(1));
    assign locked_c   = (bus.lock_in & mask_c) == mask_c;

`ifdef TAG_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0] to_cnt;

    // Counts cycles spent in WAIT_LOCK; zero on the first WAIT_LOCK cycle
    always_ff @(posedge clk) begin
        if (rst || (state != S_WAIT_LOCK)) to_cnt <= '0;
        else                               to_cnt <= to_cnt + TOW'(1);
    end

    assign to_hit_c = (to_cnt + TOW'(1)) == TOW'(TIMEOUT_CYC);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign to_hit_c       = 1'b0;
`endif

    // Next state and next registered outputs
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        n_nxt        = n_q;
        tag_nxt      = bus.tag_out;
        flush_nxt    = '0;
        buf_rstn_nxt = 1'b1;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (start_ok_c) begin
                        state_nxt    = S_CLEAR;
                        n_nxt        = bus.num_active;
                        cnt_nxt      = TW'(1);
                        buf_rstn_nxt = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_CLEAR, S_ISSUE: begin
                state_nxt = S_ISSUE;
                if (!bus.stall) begin
                    tag_nxt   = cnt;
                    flush_nxt = NUM_COL'(1) << (cnt - TW'(1));
                    if (cnt == n_q) state_nxt = S_WAIT_LOCK;
                    else            cnt_nxt   = cnt + TW'(1);
                end
            end
            S_WAIT_LOCK: begin
                // completion takes priority over a watchdog expiring in the same cycle
                if (locked_c) begin
                    state_nxt = S_FINISH;
                    done_nxt  = 1'b1;
                    tag_nxt   = '0;
                end else if (to_hit_c) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                    tag_nxt   = '0;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            n_q           <= '0;
            bus.buf_rstn  <= 1'b1;
            bus.tag_out   <= '0;
            bus.flush_out <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            n_q           <= n_nxt;
            bus.buf_rstn  <= buf_rstn_nxt;
            bus.tag_out   <= tag_nxt;
            bus.flush_out <= flush_nxt;
            bus.busy      <= (state_nxt != S_IDLE);
            bus.done      <= done_nxt;
            bus.err       <= err_nxt;
        end
    end
endmodule

// File: tb/tb_tag_issuer.sv
// Bench for tag_issuer: per-job expected timeline built from the handshake rules, compared each cycle.
// Build with TAG_TIMEOUT_EN defined to also exercise the lock-wait watchdog (limit 10).
module tb_tag_issuer;
    localparam int NC   = 4;
    localparam int TW   = 3;
    localparam int TO   = 10;
    localparam int MAXC = 64;
`ifdef TAG_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    int e_tag [MAXC];
    int e_fl  [MAXC];
    int e_busy[MAXC];
    int e_done[MAXC];
    int e_err [MAXC];
    int e_brn [MAXC];
    int rise  [NC];

    always #5 clk = ~clk;

    tag_issuer_if #(.NUM_COL(NC), .TW(TW)) bus ();

    tag_issuer #(.NUM_COL(NC), .TW(TW), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic chk_all(input string tg, input int t, input int f, input int b,
                           input int d, input int e, input int r);
        chk({tg, " tag_out"},   32'(bus.tag_out),   32'(t));
        chk({tg, " flush_out"}, 32'(bus.flush_out), 32'(f));
        chk({tg, " busy"},      32'(bus.busy),      32'(b));
        chk({tg, " done"},      32'(bus.done),      32'(d));
        chk({tg, " err"},       32'(bus.err),       32'(e));
        chk({tg, " buf_rstn"},  32'(bus.buf_rstn),  32'(r));
    endtask

    function automatic logic stall_at(input logic [15:0] stl, input int k);
        if (k >= 0 && k < 16) return stl[4'(k)];
        return 1'b0;
    endfunction

    // Idle cycles with noisy stall/lock inputs: nothing may move
    task automatic idle_chk(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            bus.start   = 1'b0;
            bus.stall   = 1'($urandom_range(0, 1));
            bus.lock_in = 4'($urandom);
            @(negedge clk);
            chk_all($sformatf("idle k=%0d", k), 0, 0, 0, 0, 0, 1);
        end
    endtask

    task automatic illegal(input int n);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_active = TW'(n); bus.stall = 1'b0; bus.lock_in = '0;
        @(negedge clk);
        chk_all($sformatf("illegal n=%0d c0", n), 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk_all($sformatf("illegal n=%0d c1", n), 0, 0, 0, 0, 1, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_all($sformatf("illegal n=%0d c2", n), 0, 0, 0, 0, 0, 1);
    endtask

    // mode: 0 = locks never arrive, 1..3 = each lock 1..mode cycles after its flush,
    // 4 = all locks arrive exactly on the last cycle before the watchdog limit
    task automatic run_job(input int n, input logic [15:0] stl, input int mode, input logic [3:0] junk);
        int  c, nxt, cur, last, end_c;
        bit  to_err, locked;
        logic [3:0] lk;
        for (int k = 0; k < MAXC; k++) begin
            e_tag[k] = 0; e_fl[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0; e_brn[k] = 1;
        end
        for (int i = 0; i < NC; i++) rise[i] = 1000;
        e_busy[1] = 1; e_brn[1] = 0;
        nxt = 1; cur = 0; c = 2;
        // issue phase: a stall seen in cycle c-1 suppresses the flush of cycle c
        while (nxt <= n) begin
            e_busy[c] = 1;
            if (!stall_at(stl, c - 1)) begin
                cur = nxt;
                e_fl[c] = 1 << (nxt - 1);
                if (mode >= 1 && mode <= 3) rise[nxt - 1] = c + int'($urandom_range(1, mode));
                nxt++;
            end
            e_tag[c] = cur;
            c++;
        end
        last = c - 1;
        if (mode == 4) for (int i = 0; i < n; i++) rise[i] = last + TO - 1;
        c = last; to_err = 1'b0;
        forever begin
            locked = 1'b1;
            for (int i = 0; i < n; i++) if (c < rise[i]) locked = 1'b0;
            if (locked) break;
            if (TO_ON && (c - last + 1 == TO)) begin to_err = 1'b1; break; end
            if (c >= MAXC - 3) break;
            c++;
            e_tag[c] = n; e_busy[c] = 1;
        end
        end_c = c + 1;
        if (to_err) e_err[end_c] = 1;
        else begin e_done[end_c] = 1; e_busy[end_c] = 1; end

        for (int k = 0; k <= end_c; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                bus.start = 1'b1; bus.num_active = TW'(n);
            end else begin
                bus.start      = (k < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.num_active = TW'($urandom_range(0, 7));
            end
            bus.stall = stall_at(stl, k);
            for (int i = 0; i < NC; i++) lk[i] = (i < n) ? (k >= rise[i]) : junk[i];
            bus.lock_in = lk;
            @(negedge clk);
            chk_all($sformatf("job n=%0d c=%0d", n, k),
                    e_tag[k], e_fl[k], e_busy[k], e_done[k], e_err[k], e_brn[k]);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.num_active = '0; bus.stall = 1'b0; bus.lock_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 1);
        rst = 1'b0;

        run_job(4, 16'h0000, 1, 4'b0000);
        run_job(3, 16'h0004, 1, 4'b0000);
        idle_chk(1);
        illegal(0);
        illegal(5);
        run_job(2, 16'h0000, 3, 4'b1100);
        run_job(1, 16'h0002, 2, 4'b1110);

        // abort mid-issue: tag 2 on the bus when rst is sampled
        @(posedge clk); #1;
        bus.start = 1'b1; bus.num_active = TW'(4); bus.stall = 1'b0; bus.lock_in = '0;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk_all("pre-reset", 2, 2, 1, 0, 0, 1);
        @(posedge clk); #1; rst = 1'b0; bus.lock_in = 4'hf;
        @(negedge clk);
        chk_all("mid-reset", 0, 0, 0, 0, 0, 1);
        idle_chk(3);

        for (int j = 0; j < 16; j++) begin
            run_job(int'($urandom_range(1, 4)), 16'($urandom) & 16'($urandom),
                    int'($urandom_range(1, 3)), 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle_chk(1);
        end
        illegal(int'($urandom_range(5, 7)));

`ifdef TAG_TIMEOUT_EN
        run_job(3, 16'h0000, 0, 4'b0000);
        idle_chk(2);
        run_job(4, 16'h0008, 4, 4'b0000);
        run_job(int'($urandom_range(1, 4)), 16'($urandom) & 16'($urandom), 0, 4'($urandom));
`endif
        idle_chk(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
